// File: rtl/serial_comp_sequencer_if.sv
// Bundle of client request/response and datapath control signals for the
// serial two's-complement sequencer; slave is the sequencer side.
interface serial_comp_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       ack;
  logic [1:0]       done;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             dp_reset_b;
  logic             dp_load;
  logic             dp_shift;
  logic [WIDTH-1:0] dp_data;
  logic             dp_y;

  modport slave (
    input  req, data0, data1, dp_y,
    output ack, done, result, busy, dp_reset_b, dp_load, dp_shift, dp_data
  );

  modport master (
    output req, data0, data1, dp_y,
    input  ack, done, result, busy, dp_reset_b, dp_load, dp_shift, dp_data
  );
endinterface

// File: rtl/serial_comp_sequencer.sv
// Round-robin two-client sequencer: clears, loads and shifts the serial
// two's-complement datapath, then deserialises its output into a result word.
module serial_comp_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                    Clock,
  input  logic                    reset,
  serial_comp_sequencer_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             winner;
  logic [WIDTH:0]   shifted;

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= 1'b1;
      gnt_q    <= 1'b0;
      hold_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      hold_q   <= hold_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    hold_d   = hold_q;
    result_d = result_q;
    // On a tie the client not served last wins; a lone request always wins.
    winner   = (bus.req == 2'b11) ? ~ptr_q : bus.req[1];
    shifted  = {bus.dp_y, result_q};

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = winner;
          hold_d  = winner ? bus.data1 : bus.data0;
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = LOAD;
      LOAD: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        result_d = shifted[WIDTH:1];
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        ptr_d   = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath reset is driven low by the module reset as well as by CLEAR.
  assign bus.dp_reset_b = ~reset & (state_q != CLEAR);
  assign bus.dp_load    = (state_q == LOAD);
  assign bus.dp_shift   = (state_q == SHIFT);
  assign bus.dp_data    = hold_q;
  assign bus.ack        = (state_q == CLEAR) ? (2'b01 << gnt_q) : 2'b00;
  assign bus.done       = (state_q == DONE) ? (2'b01 << gnt_q) : 2'b00;
  assign bus.busy       = (state_q != IDLE);
  assign bus.result     = result_q;

endmodule

// File: tb/tb_serial_comp_sequencer.sv
// Directed bench for serial_comp_sequencer with a serial datapath model and a
// per-cycle transaction-level reference model.
module tb_serial_comp_sequencer;
  localparam int WIDTH = 8;

  logic Clock = 1'b0;
  logic reset;
  always #5 Clock = ~Clock;

  serial_comp_sequencer_if #(.WIDTH(WIDTH)) bus ();

  serial_comp_sequencer #(.WIDTH(WIDTH)) dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  // Serial two's-complement datapath: y = bit XOR "a one has been seen".
  logic [WIDTH-1:0] dp_sr;
  logic             dp_flag;
  assign bus.dp_y = dp_sr[0] ^ dp_flag;

  always @(posedge Clock) begin
    if (!bus.dp_reset_b) begin
      dp_sr   <= '0;
      dp_flag <= 1'b0;
    end else if (bus.dp_load) begin
      dp_sr <= bus.dp_data;
    end else if (bus.dp_shift) begin
      dp_sr   <= dp_sr >> 1;
      dp_flag <= dp_flag | dp_sr[0];
    end
  end

  function automatic logic pick_winner(input logic [1:0] r, input logic last);
    if (r == 2'b11) return ~last;
    return r[1];
  endfunction

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return WIDTH'((1 << WIDTH) - int'(v));
  endfunction

  // Reference: an operation is a fixed schedule of offsets from its accept edge.
  logic             m_busy;
  int               m_off;
  logic             m_gnt;
  logic             m_last;
  logic [WIDTH-1:0] m_hold;
  logic [WIDTH-1:0] m_result;

  always @(posedge Clock) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_off    <= 0;
      m_gnt    <= 1'b0;
      m_last   <= 1'b1;
      m_hold   <= '0;
      m_result <= '0;
    end else if (!m_busy) begin
      if (bus.req != 2'b00) begin
        m_busy <= 1'b1;
        m_off  <= 1;
        m_gnt  <= pick_winner(bus.req, m_last);
        m_hold <= pick_winner(bus.req, m_last) ? bus.data1 : bus.data0;
      end
    end else if (m_off == WIDTH + 3) begin
      m_busy <= 1'b0;
      m_off  <= 0;
      m_last <= m_gnt;
    end else begin
      m_off <= m_off + 1;
      if (m_off == WIDTH + 2) m_result <= negate(m_hold);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  int   ack_cyc[$];
  logic ack_cli[$];
  int   done_cyc[$];
  logic done_cli[$];
  logic [WIDTH-1:0] done_res[$];

  logic [1:0] exp_onehot;
  logic       exp_shift;

  always @(negedge Clock) begin
    if (bus.ack != 2'b00) begin
      ack_cyc.push_back(cyc);
      ack_cli.push_back(bus.ack[1]);
    end
    if (bus.done != 2'b00) begin
      done_cyc.push_back(cyc);
      done_cli.push_back(bus.done[1]);
      done_res.push_back(bus.result);
    end
    if (started) begin
      exp_onehot = 2'b01 << m_gnt;
      exp_shift  = m_busy && (m_off >= 3) && (m_off <= WIDTH + 2);
      checkOutput("busy", bus.busy, m_busy);
      checkOutput("ack", bus.ack, (m_busy && m_off == 1) ? exp_onehot : 2'b00);
      checkOutput("done", bus.done, (m_busy && m_off == WIDTH + 3) ? exp_onehot : 2'b00);
      checkOutput("dp_reset_b", bus.dp_reset_b, !reset && !(m_busy && m_off == 1));
      checkOutput("dp_load", bus.dp_load, m_busy && m_off == 2);
      checkOutput("dp_shift", bus.dp_shift, exp_shift);
      checkOutput("load_shift_excl", bus.dp_load & bus.dp_shift, 1'b0);
      checkOutput("dp_data", bus.dp_data, m_hold);
      if (!exp_shift) checkOutput("result", bus.result, m_result);
    end
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [WIDTH-1:0] d0,
                               input logic [WIDTH-1:0] d1);
    @(posedge Clock);
    #1;
    bus.req   = r;
    bus.data0 = d0;
    bus.data1 = d1;
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    int k = 0;
    while (ack_cyc.size() < n && k < budget) begin
      @(negedge Clock);
      #1;
      k++;
    end
    if (ack_cyc.size() < n) checkOutput({name, "_ack_timeout"}, ack_cyc.size(), n);
  endtask

  task automatic wait_dones(input int n, input int budget, input string name);
    int k = 0;
    while (done_cyc.size() < n && k < budget) begin
      @(negedge Clock);
      #1;
      k++;
    end
    if (done_cyc.size() < n) checkOutput({name, "_done_timeout"}, done_cyc.size(), n);
  endtask

  task automatic run_single(input logic client, input logic [WIDTH-1:0] data,
                            input logic [WIDTH-1:0] exp_res, input string name);
    int t;
    int a0 = ack_cyc.size();
    int n0 = done_cyc.size();
    applyStimulus(client ? 2'b10 : 2'b01, client ? '0 : data, client ? data : '0);
    t = cyc;
    wait_acks(a0 + 1, 20, name);
    applyStimulus(2'b00, bus.data0, bus.data1);
    wait_dones(n0 + 1, 30, name);
    if (ack_cyc.size() > a0) checkOutput({name, "_ack_lat"}, ack_cyc[a0] - t, 1);
    if (done_cyc.size() > n0) begin
      checkOutput({name, "_done_lat"}, done_cyc[n0] - t, 11);
      checkOutput({name, "_client"}, done_cli[n0], client);
      checkOutput({name, "_result"}, done_res[n0], exp_res);
    end
  endtask

  task automatic pulse_reset();
    @(posedge Clock);
    #1;
    reset = 1'b1;
    @(posedge Clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int t, a0, n0, c1;
    reset     = 1'b1;
    bus.req   = 2'b00;
    bus.data0 = '0;
    bus.data1 = '0;
    repeat (2) @(posedge Clock);
    #1;
    started = 1'b1;
    @(negedge Clock);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_result", bus.result, 8'h00);
    checkOutput("rst_dp_data", bus.dp_data, 8'h00);
    checkOutput("rst_ack_done", {bus.ack, bus.done}, 4'b0000);
    checkOutput("rst_dp_reset_b", bus.dp_reset_b, 1'b0);
    @(posedge Clock);
    #1;
    reset = 1'b0;

    run_single(1'b0, 8'h01, 8'hFF, "single_01");
    run_single(1'b0, 8'h06, 8'hFA, "single_06");
    run_single(1'b0, 8'h80, 8'h80, "single_80");
    run_single(1'b0, 8'h00, 8'h00, "single_00");
    run_single(1'b1, 8'hFF, 8'h01, "single_c1_FF");

    // Tie straight after reset: client 0 first, then client 1.
    pulse_reset();
    a0 = ack_cyc.size();
    n0 = done_cyc.size();
    applyStimulus(2'b11, 8'h03, 8'h10);
    t = cyc;
    wait_acks(a0 + 1, 20, "tie");
    applyStimulus(2'b10, 8'h03, 8'h10);
    wait_acks(a0 + 2, 30, "tie");
    applyStimulus(2'b00, 8'h03, 8'h10);
    wait_dones(n0 + 2, 40, "tie");
    if (ack_cyc.size() >= a0 + 2 && done_cyc.size() >= n0 + 2) begin
      checkOutput("tie_first_client", done_cli[n0], 1'b0);
      checkOutput("tie_first_result", done_res[n0], 8'hFD);
      checkOutput("tie_first_lat", done_cyc[n0] - t, 11);
      checkOutput("tie_second_client", done_cli[n0 + 1], 1'b1);
      checkOutput("tie_second_result", done_res[n0 + 1], 8'hF0);
      checkOutput("tie_second_ack_gap", ack_cyc[a0 + 1] - done_cyc[n0], 2);
    end

    // Both held for four operations: grants alternate 0,1,0,1.
    a0 = ack_cyc.size();
    n0 = done_cyc.size();
    applyStimulus(2'b11, 8'h05, 8'h7F);
    wait_acks(a0 + 4, 80, "alt");
    applyStimulus(2'b00, 8'h05, 8'h7F);
    wait_dones(n0 + 4, 40, "alt");
    if (done_cyc.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("alt_client_%0d", i), done_cli[n0 + i], (i % 2 == 1));
        checkOutput($sformatf("alt_result_%0d", i), done_res[n0 + i],
                    (i % 2 == 1) ? 8'h81 : 8'hFB);
        if (i > 0) checkOutput($sformatf("alt_gap_%0d", i),
                               done_cyc[n0 + i] - done_cyc[n0 + i - 1], 12);
      end
    end

    // Reset asserted in the 4th shift cycle aborts without done.
    n0 = done_cyc.size();
    applyStimulus(2'b01, 8'h37, 8'h00);
    t = cyc;
    while (cyc < t + 6) begin
      @(posedge Clock);
      #1;
    end
    bus.req = 2'b00;
    reset   = 1'b1;
    @(negedge Clock);
    checkOutput("abort_in_shift", bus.dp_shift, 1'b1);
    @(posedge Clock);
    #1;
    reset = 1'b0;
    @(negedge Clock);
    checkOutput("abort_busy", bus.busy, 1'b0);
    checkOutput("abort_result", bus.result, 8'h00);
    checkOutput("abort_dp_data", bus.dp_data, 8'h00);
    checkOutput("abort_strobes", {bus.dp_load, bus.dp_shift, bus.ack, bus.done}, 6'b000000);
    repeat (15) @(negedge Clock);
    #1;
    checkOutput("abort_no_done", done_cyc.size(), n0);
    run_single(1'b0, 8'h05, 8'hFB, "rereq_05");

    // A one-cycle req[1] pulse while busy is never served.
    a0 = ack_cyc.size();
    n0 = done_cyc.size();
    applyStimulus(2'b01, 8'h22, 8'h99);
    t = cyc;
    while (cyc < t + 4) begin
      @(posedge Clock);
      #1;
    end
    bus.req = 2'b10;
    applyStimulus(2'b00, 8'h22, 8'h99);
    wait_dones(n0 + 1, 30, "withdraw");
    repeat (15) @(negedge Clock);
    #1;
    c1 = 0;
    for (int i = a0; i < ack_cyc.size(); i++) if (ack_cli[i]) c1++;
    for (int i = n0; i < done_cyc.size(); i++) if (done_cli[i]) c1++;
    checkOutput("withdraw_no_client1", c1, 0);
    checkOutput("withdraw_ops", done_cyc.size() - n0, 1);
    if (done_cyc.size() > n0) checkOutput("withdraw_result", done_res[n0], 8'hDE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_comp_sequencer.md
# serial_comp_sequencer

Sequencer and two-port arbiter for the serial two's-complement datapath (8-bit shift register plus carry flag, controlled by `load`/`shift_control`, cleared by active-low `reset_b`, serial output `y`). It accepts whole-word requests from two clients and round-robins between them. For each accepted request it clears the datapath, loads the word, and issues exactly WIDTH shifts. It deserialises `y` into a parallel result and returns that result with a one-cycle done strobe to the requester that was served.

## Interface
- `WIDTH`, default 8: word width; equals the datapath shift-register width.
- `Clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  2  level request per client; bit i = client i.
- `data0`  in  WIDTH  operand of client 0; sampled only at the accept edge.
- `data1`  in  WIDTH  operand of client 1; sampled only at the accept edge.
- `ack`  out  2  one-hot, one-cycle pulse: the request has been accepted.
- `done`  out  2  one-hot, one-cycle pulse: `result` is valid for that client.
- `result`  out  WIDTH  two's complement of the accepted operand.
- `busy`  out  1  high in every state except IDLE.
- `dp_reset_b`  out  1  drives datapath `reset_b`; active low.
- `dp_load`  out  1  drives datapath `load`.
- `dp_shift`  out  1  drives datapath `shift_control`.
- `dp_data`  out  WIDTH  drives datapath `data`.
- `dp_y`  in  1  datapath serial output `y` (combinational, LSB first).

## Operation
- States: IDLE, CLEAR, LOAD, SHIFT, DONE.
- **IDLE**
  - If any `req` bit is high, pick a winner. Latch its data into the hold register and the winner index into `gnt`. Go to CLEAR.
  - If no `req` bit is high, stay in IDLE.
- **CLEAR**
  - `dp_reset_b`=0 for exactly this cycle, which clears the datapath shift register and carry flag.
  - `ack[gnt]`=1.
  - Next state: LOAD.
- **LOAD**
  - `dp_load`=1 and `dp_data`=hold register.
  - Next state: SHIFT, with the bit counter set to 0.
- **SHIFT**
  - `dp_shift`=1.
  - Each cycle: `result` <= {`dp_y`, `result`[WIDTH-1:1]}, and the counter increments.
  - When the counter reaches WIDTH-1, that cycle is the last shift. Next state: DONE.
- **DONE**
  - `done[gnt]`=1. `result` holds the final value.
  - The round-robin pointer is updated to `gnt`.
  - Next state: IDLE.
- **Arbitration**
  - A single request is granted unconditionally.
  - When both clients request, the grant goes to the client not served last.
  - After reset the pointer is 1, so client 0 wins the first tie.
- **Request rules**
  - `req` is examined only in IDLE.
  - A request dropped before it is sampled is simply not served: no `ack`, no `done`.
  - `req` still high at the next IDLE counts as a new request.
  - Clients drop `req` after `ack`.
- **Output stability**
  - `result` holds its last value until the next SHIFT overwrites it.
  - `dp_data` holds the hold register at all times.
  - `dp_load` and `dp_shift` are never high together.
  - `dp_load` and `dp_shift` are both 0 in IDLE, CLEAR and DONE.
- **Datapath output used**
  - `dp_y` is sampled only in SHIFT. Bit k sampled equals bit k of (−operand mod 2^WIDTH).

## Timing
- **Reset** (synchronous; takes effect at the edge where `reset`=1)
  - State goes to IDLE, pointer to 1, counter to 0.
  - `result`, the hold register and `dp_data` go to 0.
  - `ack`, `done`, `busy`, `dp_load` and `dp_shift` are 0.
  - `dp_reset_b` is 0 whenever `reset`=1, otherwise it follows the rules above.
- **Latency:** request sampled in IDLE cycle t gives `ack` at t+1, `dp_load` at t+2, shifts at t+3..t+WIDTH+2, and `done` at t+WIDTH+3.
- **Throughput:** at most one operation per WIDTH+4 cycles, since IDLE lasts at least 1 cycle.
- **Reset during any non-IDLE state:** the operation aborts. No `done` is issued, and the pending client must re-request.
- **Reset and request in the same cycle:** reset wins; the request is not accepted.
- **Counter width:** clog2(WIDTH); it never wraps past WIDTH-1.

## Test plan
- **Single requests, WIDTH=8:** client 0 requests with `data0`=0x01 -> `ack`=01 at t+1, `done`=01 at t+11, `result`=0xFF. Repeat for 0x06 -> 0xFA, 0x80 -> 0x80, 0x00 -> 0x00.
- **Simultaneous requests after reset:** both request, `data0`=0x03, `data1`=0x10. Client 0 is served first with `result`=0xFD. Client 1 follows with `ack` at the cycle after the first IDLE, `result`=0xF0.
- **Alternation:** hold both `req` high for 4 operations -> grants alternate 0,1,0,1. Each `done` is exactly 12 cycles after the previous one.
- **Datapath strobe check:** every operation shows exactly 1 `dp_reset_b` low cycle, then 1 `dp_load` cycle, then 8 consecutive `dp_shift` cycles, in that order and never overlapping.
- **Reset mid-SHIFT:** assert `reset` in the 4th shift cycle -> the next cycle is IDLE with all outputs at reset values and no `done`. A re-request of 0x05 then gives 0xFB.
- **Withdrawn request:** pulse `req[1]` for one cycle while `busy` -> no `ack` or `done` is ever issued for client 1.
